// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divided-clock monitors: measurement FSM
// states, default counter width and the tolerance compare.
package clk_mon_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int CMP_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } mon_state_e;

  // Operands are zero-extended and subtracted one bit wider, so the
  // difference is a true signed value and cannot wrap.
  function automatic logic out_of_tol(
    input logic [CMP_W-1:0] meas,
    input logic [CMP_W-1:0] expv,
    input logic [CMP_W-1:0] tol
  );
    logic [CMP_W:0] diff;
    logic [CMP_W:0] mag;
    diff = {1'b0, meas} - {1'b0, expv};
    mag  = diff[CMP_W] ? -diff : diff;
    return (mag > {1'b0, tol});
  endfunction

endpackage

// File: rtl/clk_div_monitor_edge_sync3.sv
// Three-flop synchronizer for a slow data-sampled clock, with rise/fall
// detection on the last two stages (two-cycle detection latency).
module edge_sync3 (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic d_in,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // Next value of each synchronizer stage.
  always_comb begin
    s1_d = d_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchronizer flops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in sys_clk cycles and
// flags out-of-tolerance ratio/duty and stuck-clock conditions.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EXP_PERIOD = 5,
  parameter int EXP_HIGH   = 3,
  parameter int TOL        = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clk_in,
  input  logic             enable,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             freq_err,
  output logic             stuck_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_tmp_q, hi_tmp_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             freq_err_q, freq_err_d;
  logic             stuck_err_q, stuck_err_d;

  logic rise_s, fall_s;
  logic cnt_sat_s;
  logic valid_evt_s, hi_latch_s, stuck_evt_s;
  logic tol_fail_s;

  edge_sync3 u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .d_in      (clk_in),
    .rise      (rise_s),
    .fall      (fall_s)
  );

  // Saturated counter with no edge this cycle means the clock has stopped.
  assign cnt_sat_s = (cnt_q == CNT_MAX) & ~rise_s & ~fall_s;

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; disable aborts from any active state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = ARM;
        else        state_d = IDLE;
      end
      ARM: begin
        if (!enable)     state_d = IDLE;
        else if (rise_s) state_d = HIGH;
        else             state_d = ARM;
      end
      HIGH: begin
        if (!enable)        state_d = IDLE;
        else if (fall_s)    state_d = LOW;
        else if (cnt_sat_s) state_d = ARM;
        else                state_d = HIGH;
      end
      LOW: begin
        if (!enable)        state_d = IDLE;
        else if (rise_s)    state_d = HIGH;
        else if (cnt_sat_s) state_d = ARM;
        else                state_d = LOW;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM event decode driving the datapath.
  always_comb begin
    valid_evt_s = 1'b0;
    hi_latch_s  = 1'b0;
    stuck_evt_s = 1'b0;
    case (state_q)
      IDLE: begin
        valid_evt_s = 1'b0;
      end
      ARM: begin
        stuck_evt_s = enable & cnt_sat_s;
      end
      HIGH: begin
        hi_latch_s  = enable & fall_s;
        stuck_evt_s = enable & cnt_sat_s;
      end
      LOW: begin
        valid_evt_s = enable & rise_s;
        stuck_evt_s = enable & cnt_sat_s;
      end
      default: begin
        valid_evt_s = 1'b0;
      end
    endcase
  end

  assign tol_fail_s = out_of_tol(CMP_W'(cnt_q), CMP_W'(EXP_PERIOD), CMP_W'(TOL))
                    | out_of_tol(CMP_W'(hi_tmp_q), CMP_W'(EXP_HIGH), CMP_W'(TOL));

  // Counter, result and sticky-flag next values; a set beats err_clr.
  always_comb begin
    if (rise_s)                cnt_d = CNT_ONE;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CNT_ONE;

    if (hi_latch_s) hi_tmp_d = cnt_q;
    else            hi_tmp_d = hi_tmp_q;

    if (valid_evt_s) begin
      period_d    = cnt_q;
      high_time_d = hi_tmp_q;
    end else begin
      period_d    = period_q;
      high_time_d = high_time_q;
    end
    meas_valid_d = valid_evt_s;

    if (valid_evt_s && tol_fail_s) freq_err_d = 1'b1;
    else if (err_clr)              freq_err_d = 1'b0;
    else                           freq_err_d = freq_err_q;

    if (stuck_evt_s)  stuck_err_d = 1'b1;
    else if (err_clr) stuck_err_d = 1'b0;
    else              stuck_err_d = stuck_err_q;
  end

  // Datapath and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q        <= '0;
      hi_tmp_q     <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      freq_err_q   <= 1'b0;
      stuck_err_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      hi_tmp_q     <= hi_tmp_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      freq_err_q   <= freq_err_d;
      stuck_err_q  <= stuck_err_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign freq_err   = freq_err_q;
  assign stuck_err  = stuck_err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: clk_in waveforms are driven per
// sys_clk cycle and expected measurements are queued and popped on meas_valid.
module tb_clk_div_monitor;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       clk_in    = 1'b0;
  logic       enable    = 1'b0;
  logic       err_clr   = 1'b0;
  logic [7:0] period;
  logic [7:0] high_time;
  logic       meas_valid;
  logic       freq_err;
  logic       stuck_err;

  typedef struct packed {
    logic [7:0] p;
    logic [7:0] h;
    logic       f;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 sys_clk = ~sys_clk;

  clk_div_monitor #(
    .CNT_W      (8),
    .EXP_PERIOD (5),
    .EXP_HIGH   (3),
    .TOL        (1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .clk_in     (clk_in),
    .enable     (enable),
    .err_clr    (err_clr),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .freq_err   (freq_err),
    .stuck_err  (stuck_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  task automatic expect_meas(input logic [7:0] p, input logic [7:0] h, input logic f);
    exp_t e;
    e.p = p;
    e.h = h;
    e.f = f;
    sb.push_back(e);
  endtask

  // One sys_clk cycle: drive inputs, then check outputs on the falling edge.
  task automatic step(input logic cv, input logic clr);
    exp_t e;
    clk_in  = cv;
    err_clr = clr;
    @(negedge sys_clk);
    if (meas_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'(meas_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("period", 32'(period), 32'(e.p));
        chk("high_time", 32'(high_time), 32'(e.h));
        chk("freq_err_at_valid", 32'(freq_err), 32'(e.f));
      end
    end
  endtask

  // One clk_in period (high first); its rise completes the previous period.
  task automatic pw(input int p, input int h, input int clr_at, input logic v,
                    input logic [7:0] ep, input logic [7:0] eh, input logic ef);
    if (v) expect_meas(ep, eh, ef);
    for (int i = 0; i < p; i++) begin
      step(i < h, i == clr_at);
      if (i == 2) chk("valid_timing", 32'(meas_valid), 32'(v));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge sys_clk);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_high_time", 32'(high_time), 32'd0);
    chk("rst_meas_valid", 32'(meas_valid), 32'd0);
    chk("rst_freq_err", 32'(freq_err), 32'd0);
    chk("rst_stuck_err", 32'(stuck_err), 32'd0);
    sys_rst_n = 1'b1;
    enable    = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Nominal 5/3: first rise only arms
    pw(5, 3, -1, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int k = 0; k < 5; k++) pw(5, 3, -1, 1'b1, 8'd5, 8'd3, 1'b0);
    chk("nom_freq_err", 32'(freq_err), 32'd0);
    chk("nom_stuck_err", 32'(stuck_err), 32'd0);

    // Ratio fault 7/4, then err_clr after an in-tolerance measurement
    pw(7, 4, -1, 1'b1, 8'd5, 8'd3, 1'b0);
    pw(7, 4, -1, 1'b1, 8'd7, 8'd4, 1'b1);
    pw(5, 3, -1, 1'b1, 8'd7, 8'd4, 1'b1);
    chk("ratio_sticky", 32'(freq_err), 32'd1);
    pw(5, 3, 4, 1'b1, 8'd5, 8'd3, 1'b1);
    chk("ratio_cleared", 32'(freq_err), 32'd0);

    // Collision: err_clr on the cycle an out-of-tolerance result lands
    pw(7, 4, -1, 1'b1, 8'd5, 8'd3, 1'b0);
    pw(5, 3, 2, 1'b1, 8'd7, 8'd4, 1'b1);
    chk("collision_set_wins", 32'(freq_err), 32'd1);
    pw(5, 3, -1, 1'b1, 8'd5, 8'd3, 1'b1);

    // Stuck high for 300 cycles
    expect_meas(8'd5, 8'd3, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0);
      if (i == 256) chk("stuck_not_yet", 32'(stuck_err), 32'd0);
      if (i == 257) chk("stuck_set", 32'(stuck_err), 32'd1);
    end
    chk("stuck_held", 32'(stuck_err), 32'd1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    pw(5, 3, -1, 1'b0, 8'd0, 8'd0, 1'b0);
    pw(5, 3, -1, 1'b1, 8'd5, 8'd3, 1'b1);
    pw(5, 3, -1, 1'b1, 8'd5, 8'd3, 1'b1);
    step(1'b0, 1'b1);
    chk("clr_stuck", 32'(stuck_err), 32'd0);
    chk("clr_freq", 32'(freq_err), 32'd0);

    // Period 6 is at the tolerance edge; then abort during HIGH
    expect_meas(8'd6, 8'd3, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    enable = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    enable = 1'b1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("abort_keep_period", 32'(period), 32'd6);
    chk("abort_keep_high", 32'(high_time), 32'd3);
    chk("abort_freq_err", 32'(freq_err), 32'd0);
    pw(5, 3, -1, 1'b0, 8'd0, 8'd0, 1'b0);
    pw(5, 3, -1, 1'b1, 8'd5, 8'd3, 1'b0);
    pw(5, 3, -1, 1'b1, 8'd5, 8'd3, 1'b0);

    // Asynchronous reset mid-LOW
    chk("sb_empty_before_reset", 32'(sb.size()), 32'd0);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_period", 32'(period), 32'd0);
    chk("arst_high_time", 32'(high_time), 32'd0);
    chk("arst_meas_valid", 32'(meas_valid), 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    pw(5, 3, -1, 1'b0, 8'd0, 8'd0, 1'b0);
    pw(5, 3, -1, 1'b1, 8'd5, 8'd3, 1'b0);
    pw(5, 3, -1, 1'b1, 8'd5, 8'd3, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    chk("final_freq_err", 32'(freq_err), 32'd0);
    chk("final_stuck_err", 32'(stuck_err), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
